i2c_slave_regfile: RTL
======================

// Module: i2c_slave_regfile
// PURPOSE
//  Synthesizable I2C responder (slave) with an internal 8-bit register file, the far end of the I2C master used for video codec setup.
//  Lets an on-FPGA master be tested in closed loop, or lets the FPGA act as a configurable I2C peripheral.
//  Supports sub-address writes, sub-address reads (repeated START), and auto-increment.
// PARAMETERS
//  SLAVE_ADDR  7'h76  7-bit device address matched after START
//  ADDR_W      8      register pointer width; REG_COUNT = 2**ADDR_W, pointer = low ADDR_W bits of sub-address byte
// PORTS
//  clk          in   1       system clock; every internal register is clocked on its rising edge
//  rst          in   1       synchronous, active-high reset
//  scl_i        in   1       raw SCL from pad (asynchronous)
//  sda_i        in   1       raw SDA from pad (asynchronous)
//  sda_oe       out  1       1 = drive SDA low (open drain), 0 = release
//  reg_wr_valid out  1       one-cycle pulse per committed write byte
//  reg_wr_addr  out  ADDR_W  register written
//  reg_wr_data  out  8       byte written
//  host_rd_addr in   ADDR_W  fabric-side read address
//  host_rd_data out  8       regfile[host_rd_addr], registered: 1-cycle latency
// BEHAVIOUR
//  - scl_i/sda_i pass through 2-flop synchronizers. Edges are detected on the synchronized values.
//  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in every state, including mid-byte.
//  - START (or repeated START) -> ADDR with bit_cnt = 0. STOP -> IDLE and sda_oe = 0.
//  - Bits are sampled on the SCL rising edge, MSB first. sda_oe changes only in the cycle after a detected SCL falling edge.
//  - Reset: state = IDLE, sda_oe = 0, reg_wr_valid = 0, reg_wr_addr = 0, reg_wr_data = 0, pointer = 0, host_rd_data = 0, all registers = 8'h00.
//  - States and transitions:
//      IDLE -> ADDR on START.
//      ADDR: after 8 bits, compare [7:1] with SLAVE_ADDR. Match -> ACK_ADDR (drive low for the 9th clock). Mismatch -> WAIT_STOP, never driving.
//      ACK_ADDR: R/W = 0 -> SUBADDR. R/W = 1 -> READ, with the shift register loaded from regfile[pointer].
//      SUBADDR: 8 bits -> pointer, then ACK_SUB -> WDATA.
//      WDATA: 8 bits -> regfile[pointer] is written; reg_wr_valid pulses in the cycle of the 8th SCL rise; then ACK_DATA.
//        pointer increments after the pulse. ACK_DATA -> WDATA.
//      READ: for each of the 8 bits, sda_oe = ~shift[7]. On the 9th clock sda_oe = 0 and the master's ACK is sampled.
//        ACK (0) -> pointer++, reload, READ. NACK (1) -> WAIT_STOP.
//      WAIT_STOP: ignore everything until STOP or START.
//  - Pointer wraps from REG_COUNT-1 to 0. The pointer survives STOP, so a read without a sub-address continues from the last position.
//  - Host read and I2C write to the same address in the same cycle: host_rd_data returns the old value.
//  - A START mid-byte discards the partial byte; no write is committed.
//  - rst asserted mid-transfer: returns to IDLE next cycle and releases SDA immediately.
// CONFIGURATION
//  I2C_SLAVE_GLITCH_FILTER_EN:
//    defined: synchronized SCL/SDA additionally pass a 3-sample majority filter, adding 2 cycles of latency. Pulses of 1 clk are rejected.
//    undefined: no filter; the synchronizer output is used directly.
// STRUCTURE
//  - Header i2c_slave_defs.vh: state encodings (IDLE, ADDR, ACK_ADDR, SUBADDR, ACK_SUB, WDATA, ACK_DATA, READ, WAIT_STOP), the state width, and RW_READ/RW_WRITE.
//  - Sub-module i2c_line_sync: synchronizer, optional filter and rise/fall edge detection. Instantiated once for SCL and once for SDA.
//  - Top level: FSM, bit counter, shift register, pointer, regfile array.
// TESTING (bench: pull-up modelled as sda = sda_oe ? 0 : 1; SCL about 100 kHz at 100 MHz clk)
//  1. Write: START, 0xEC, 0x49, 0xC0, STOP -> three ACKs; one reg_wr_valid with addr 0x49, data 0xC0; host read of 0x49 returns 0xC0 one cycle later.
//  2. Burst write then read: START 0xEC 0x10 0xAA 0xBB STOP, then START 0xEC 0x10 Sr 0xED, read 2 (ACK, NACK), STOP -> 0xAA, 0xBB returned; sda_oe = 0 after NACK.
//  3. Address mismatch: START 0xEE 0x00 0x55 STOP -> sda_oe stays 0 for the whole transfer; no reg_wr_valid.
//  4. Wrap: write to 0xFF, then 0x01, 0x02 -> regfile[0xFF] = 0x01, regfile[0x00] = 0x02.
//  5. Abort: rst pulsed mid-data byte, then START 0xEC 0x20 0x33 STOP -> sda_oe = 0 during reset; second transfer ACKed; regfile[0x20] = 0x33.
//  6. Filter build: a 1-clk SDA low glitch while SCL is high -> with _EN no START is detected; without _EN a START is detected.

Source files
------------

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types for the I2C responder: FSM state encoding, R/W bit values and bit-counter marks.
package i2c_slave_regfile_pkg;

  localparam int STATE_W = 4;

  // state        | meaning
  // ST_IDLE      | bus idle, waiting for START
  // ST_ADDR      | shifting in device address + R/W
  // ST_ACK_ADDR  | driving ACK for our address
  // ST_SUBADDR   | shifting in register pointer
  // ST_ACK_SUB   | driving ACK for the pointer byte
  // ST_WDATA     | shifting in a write data byte
  // ST_ACK_DATA  | driving ACK for the data byte
  // ST_READ      | shifting out regfile[pointer], then sampling master ACK
  // ST_WAIT_STOP | not addressed or NACKed; ignore bus until START/STOP
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE, ST_ADDR, ST_ACK_ADDR, ST_SUBADDR, ST_ACK_SUB,
    ST_WDATA, ST_ACK_DATA, ST_READ, ST_WAIT_STOP
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [3:0] BIT_LAST     = 4'd7;
  localparam logic [3:0] BIT_ACK      = 4'd8;
  localparam logic [3:0] BIT_ACK_DONE = 4'd9;

endpackage

// File: rtl/i2c_slave_regfile_line_sync.sv
// Two-flop synchronizer plus rise/fall detect for one I2C line.
// I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter that drops 1-clk pulses.
module i2c_slave_regfile_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       level_q;

  // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], line_raw};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C responder with 2**ADDR_W x 8 register file: sub-address writes, repeated-START reads, auto-increment.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h76,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              reg_wr_valid,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [7:0]        host_rd_data
);

  localparam int REG_COUNT = 2**ADDR_W;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_slave_regfile_line_sync u_scl_sync (
    .clk(clk), .rst(rst), .line_raw(scl_i), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_slave_regfile_line_sync u_sda_sync (
    .clk(clk), .rst(rst), .line_raw(sda_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              oe_nxt, wr_en;
  logic [7:0]        rx_byte;
  logic [7:0]        regs [REG_COUNT];

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign rx_byte   = {shift[6:0], sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      ptr          <= '0;
      sda_oe       <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      ptr          <= ptr_nxt;
      sda_oe       <= oe_nxt;
      reg_wr_valid <= wr_en;
      if (wr_en) begin
        reg_wr_addr <= ptr;
        reg_wr_data <= rx_byte;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    ptr_nxt     = ptr;
    oe_nxt      = sda_oe;
    wr_en       = 1'b0;
    if (start_det) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
    end else if (stop_det) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_SUBADDR, ST_WDATA: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == BIT_LAST) begin
              if (state == ST_ADDR) begin
                state_nxt = (rx_byte[7:1] == SLAVE_ADDR) ? ST_ACK_ADDR : ST_WAIT_STOP;
              end else if (state == ST_SUBADDR) begin
                ptr_nxt   = rx_byte[ADDR_W-1:0];
                state_nxt = ST_ACK_SUB;
              end else begin
                wr_en     = 1'b1;
                ptr_nxt   = ptr + 1'b1;
                state_nxt = ST_ACK_DATA;
              end
            end
          end
        end
        // bit_cnt = 8: waiting for the 8th fall to start driving; 9: ACK clock seen, release on its fall.
        ST_ACK_ADDR, ST_ACK_SUB, ST_ACK_DATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = BIT_ACK_DONE;
          end else if (scl_fall) begin
            if (bit_cnt == BIT_ACK) begin
              oe_nxt = 1'b1;
            end else begin
              bit_cnt_nxt = '0;
              oe_nxt      = 1'b0;
              state_nxt   = ST_WDATA;
              if (state == ST_ACK_ADDR) begin
                case (shift[0])
                  RW_WRITE: state_nxt = ST_SUBADDR;
                  RW_READ: begin
                    state_nxt = ST_READ;
                    shift_nxt = regs[ptr];
                    oe_nxt    = ~regs[ptr][7];
                  end
                endcase
              end
            end
          end
        end
        ST_READ: begin
          if (scl_rise) begin
            if (bit_cnt == BIT_ACK) begin
              if (!sda) begin
                ptr_nxt     = ptr + 1'b1;
                bit_cnt_nxt = BIT_ACK_DONE;
              end else begin
                state_nxt = ST_WAIT_STOP;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end else if (scl_fall) begin
            if (bit_cnt == BIT_ACK_DONE) begin
              bit_cnt_nxt = '0;
              shift_nxt   = regs[ptr];
              oe_nxt      = ~regs[ptr][7];
            end else if (bit_cnt == BIT_ACK) begin
              oe_nxt = 1'b0;
            end else if (bit_cnt != 4'd0) begin
              shift_nxt = {shift[6:0], 1'b0};
              oe_nxt    = ~shift[6];
            end
          end
        end
        ST_IDLE, ST_WAIT_STOP: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[ptr] <= rx_byte;
    end
  end

  // Read-before-write: a same-cycle I2C write to host_rd_addr returns the old byte.
  always_ff @(posedge clk) begin
    if (rst) host_rd_data <= 8'h00;
    else     host_rd_data <= regs[host_rd_addr];
  end

endmodule
